// File: rtl/chip8_alu_exec.sv
// chip8_alu_exec: multi-cycle sequencer for CHIP-8 8XYN ALU instructions (read Vx/Vy, drive ALU, write Vx then VF).
// Optional: define CHIP8_VF_RESET_QUIRK_EN to clear VF after OR/AND/XOR.
package chip8_alu_pkg;
  typedef enum logic [2:0] {
    ALU_f_NOP, ALU_f_OR, ALU_f_AND, ALU_f_XOR, ALU_f_ADD, ALU_f_MINUS, ALU_f_RSHIFT, ALU_f_LSHIFT
  } ALU_f;
endpackage

module chip8_alu_exec
  import chip8_alu_pkg::*;
#(
  parameter logic [3:0] FLAG_REG = 4'hF,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [15:0]       opcode,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [3:0]        reg_raddr_a,
  input  logic [DATA_W-1:0] reg_rdata_a,
  output logic [3:0]        reg_raddr_b,
  input  logic [DATA_W-1:0] reg_rdata_b,
  output logic              reg_we,
  output logic [3:0]        reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic [15:0]       alu_in1,
  output logic [15:0]       alu_in2,
  output ALU_f              alu_sel,
  input  logic [15:0]       alu_out,
  input  logic              alu_carry
);
`ifdef CHIP8_VF_RESET_QUIRK_EN
  localparam bit QUIRK = 1'b1;
`else
  localparam bit QUIRK = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, READ, EXEC, WB_X, WB_F, ERR} state_t;
  state_t state, state_n;
  logic [3:0] x, n;
  logic [DATA_W-1:0] op_a, op_b, res, res_n;
  logic flag, flag_n, legal, has_flag, unused_hi;
  assign unused_hi = ^alu_out[15:DATA_W];
  assign legal = opcode[15:12] == 4'h8 && (opcode[3] == 1'b0 || opcode[3:0] == 4'hE);
  assign has_flag = n inside {4'h4, 4'h5, 4'h6, 4'h7, 4'hE} || (QUIRK && n inside {4'h1, 4'h2, 4'h3});
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x <= '0;
      n <= '0;
      op_a <= '0;
      op_b <= '0;
      res <= '0;
      flag <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        x <= opcode[11:8];
        n <= opcode[3:0];
      end
      if (state == READ) begin
        op_a <= reg_rdata_a;
        op_b <= reg_rdata_b;
      end
      if (state == EXEC) begin
        res <= res_n;
        flag <= flag_n;
      end
    end
  end
  always_comb begin
    state_n = state;
    busy = state != IDLE;
    done = 1'b0;
    illegal = 1'b0;
    reg_raddr_a = '0;
    reg_raddr_b = '0;
    reg_we = 1'b0;
    reg_waddr = '0;
    reg_wdata = '0;
    alu_in1 = '0;
    alu_in2 = '0;
    alu_sel = ALU_f_NOP;
    res_n = res;
    flag_n = flag;
    case (state)
      IDLE: if (start) begin
        state_n = legal ? READ : ERR;
        reg_raddr_a = opcode[11:8];
        reg_raddr_b = opcode[7:4];
      end
      READ: state_n = EXEC;
      EXEC: begin
        state_n = WB_X;
        // 8XY7 computes Vy - Vx, so the operands swap ALU ports
        alu_in1 = n == 4'h7 ? 16'(op_b) : 16'(op_a);
        alu_in2 = n == 4'h7 ? 16'(op_a) : (n == 4'h6 || n == 4'hE) ? 16'd1 : 16'(op_b);
        alu_sel = n == 4'h1 ? ALU_f_OR : n == 4'h2 ? ALU_f_AND : n == 4'h3 ? ALU_f_XOR :
                  n == 4'h4 ? ALU_f_ADD : (n == 4'h5 || n == 4'h7) ? ALU_f_MINUS :
                  n == 4'h6 ? ALU_f_RSHIFT : n == 4'hE ? ALU_f_LSHIFT : ALU_f_NOP;
        res_n = n == 4'h0 ? op_b : alu_out[DATA_W-1:0];
        flag_n = n == 4'h4 ? alu_carry : (n == 4'h5 || n == 4'h7) ? ~alu_carry :
                 n == 4'h6 ? op_a[0] : n == 4'hE ? op_a[DATA_W-1] : 1'b0;
      end
      WB_X: begin
        reg_we = 1'b1;
        reg_waddr = x;
        reg_wdata = res;
        done = !has_flag;
        state_n = has_flag ? WB_F : IDLE;
      end
      WB_F: begin
        reg_we = 1'b1;
        reg_waddr = FLAG_REG;
        reg_wdata = DATA_W'(flag);
        done = 1'b1;
        state_n = IDLE;
      end
      ERR: begin
        done = 1'b1;
        illegal = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
